// File: rtl/snitch_icache_pkg.sv
// Shared types and constants for the icache refill writer and its victim selector.
// Optional feature macro: SNITCH_ICACHE_REFILL_LFSR_EN (pseudo-random victim selection).
package snitch_icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } refill_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/snitch_icache_refill_victim.sv
// Victim set selector: round-robin counter, or an 8-bit LFSR when
// SNITCH_ICACHE_REFILL_LFSR_EN is defined. Advances per completed write, flush reseeds.
module snitch_icache_refill_victim
    import snitch_icache_pkg::*;
#(
    parameter int unsigned SET_COUNT = 2,
    parameter int unsigned SET_ALIGN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 advance,
    input  logic                 flush,
    output logic [SET_ALIGN-1:0] victim
);

`ifdef SNITCH_ICACHE_REFILL_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= LFSR_SEED;
        end else if (flush) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    if (SET_COUNT > 1) begin : gen_multi_set
        assign victim = lfsr[SET_ALIGN-1:0];
    end else begin : gen_single_set
        assign victim = '0;
    end
`else
    logic [SET_ALIGN-1:0] count;

    // Flush has priority so a flush coinciding with a write leaves the counter at 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (advance) begin
            count <= (SET_COUNT > 1) ? count + SET_ALIGN'(1) : '0;
        end
    end

    assign victim = count;
`endif

endmodule

// File: rtl/snitch_icache_refill_writer.sv
// Refill writer: takes one miss, assembles FILL_DW beats into a line and issues one
// lookup write. Victim policy selectable with SNITCH_ICACHE_REFILL_LFSR_EN.
module snitch_icache_refill_writer
    import snitch_icache_pkg::*;
#(
    parameter  int unsigned FETCH_AW    = 32,
    parameter  int unsigned LINE_WIDTH  = 128,
    parameter  int unsigned FILL_DW     = 64,
    parameter  int unsigned LINE_COUNT  = 64,
    parameter  int unsigned SET_COUNT   = 2,
    parameter  int unsigned ID_WIDTH    = 4,
    localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8),
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
    localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [FETCH_AW-1:0]    req_addr_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [FILL_DW-1:0]     fill_data_i,
    input  logic                   fill_error_i,
    input  logic                   fill_last_i,
    input  logic                   fill_valid_i,
    output logic                   fill_ready_o,
    output logic [COUNT_ALIGN-1:0] write_addr_o,
    output logic [SET_ALIGN-1:0]   write_set_o,
    output logic [LINE_WIDTH-1:0]  write_data_o,
    output logic [TAG_WIDTH-1:0]   write_tag_o,
    output logic                   write_error_o,
    output logic                   write_valid_o,
    input  logic                   write_ready_i,
    output logic [ID_WIDTH-1:0]    done_id_o,
    output logic                   done_valid_o
);

    localparam int unsigned BEATS = LINE_WIDTH / FILL_DW;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    refill_state_e       state;
    logic [CNT_W-1:0]    cnt;
    logic [ID_WIDTH-1:0] id;
    logic                req_hs;
    logic                fill_hs;
    logic                write_hs;
    logic                last_cnt;

    assign req_hs   = req_valid_i & req_ready_o;
    assign fill_hs  = fill_valid_i & fill_ready_o;
    assign write_hs = write_valid_o & write_ready_i;
    assign last_cnt = (cnt == CNT_W'(BEATS - 1));

    // Completion is reported in the handshake cycle itself
    assign done_valid_o = write_hs;
    assign done_id_o    = id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            req_ready_o   <= 1'b1;
            fill_ready_o  <= 1'b0;
            write_valid_o <= 1'b0;
            cnt           <= '0;
            id            <= '0;
            write_addr_o  <= '0;
            write_tag_o   <= '0;
            write_data_o  <= '0;
            write_error_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        state         <= COLLECT;
                        req_ready_o   <= 1'b0;
                        fill_ready_o  <= 1'b1;
                        write_tag_o   <= TAG_WIDTH'(req_addr_i >> (LINE_ALIGN + COUNT_ALIGN));
                        write_addr_o  <= COUNT_ALIGN'(req_addr_i >> LINE_ALIGN);
                        id            <= req_id_i;
                        cnt           <= '0;
                        write_error_o <= 1'b0;
                        write_data_o  <= '0;
                    end
                end
                COLLECT: begin
                    if (fill_hs) begin
                        for (int unsigned b = 0; b < BEATS; b++) begin
                            if (cnt == CNT_W'(b)) begin
                                write_data_o[b*FILL_DW +: FILL_DW] <= fill_data_i;
                            end
                        end
                        cnt <= cnt + CNT_W'(1);
                        // Burst length disagreeing with the line size taints the line
                        write_error_o <= write_error_o | fill_error_i | (fill_last_i ^ last_cnt);
                        if (last_cnt || fill_last_i) begin
                            state         <= WRITE;
                            fill_ready_o  <= 1'b0;
                            write_valid_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (write_hs) begin
                        state         <= IDLE;
                        write_valid_o <= 1'b0;
                        req_ready_o   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    snitch_icache_refill_victim #(
        .SET_COUNT(SET_COUNT),
        .SET_ALIGN(SET_ALIGN)
    ) i_victim (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .advance(write_hs),
        .flush  (flush_i),
        .victim (write_set_o)
    );

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Scoreboard bench for snitch_icache_refill_writer: driver pushes expected writes,
// a monitor pops and compares on every write handshake. Honours SNITCH_ICACHE_REFILL_LFSR_EN.
module tb_snitch_icache_refill_writer;

    typedef struct {
        logic [5:0]   addr;
        logic [0:0]   set;
        logic [127:0] data;
        logic [21:0]  tag;
        logic         err;
        logic [3:0]   id;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [31:0]  req_addr_i;
    logic [3:0]   req_id_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [63:0]  fill_data_i;
    logic         fill_error_i;
    logic         fill_last_i;
    logic         fill_valid_i;
    logic         fill_ready_o;
    logic [5:0]   write_addr_o;
    logic [0:0]   write_set_o;
    logic [127:0] write_data_o;
    logic [21:0]  write_tag_o;
    logic         write_error_o;
    logic         write_valid_o;
    logic         write_ready_i;
    logic [3:0]   done_id_o;
    logic         done_valid_o;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk_i = ~clk_i;

    snitch_icache_refill_writer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req_addr_i   (req_addr_i),
        .req_id_i     (req_id_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .fill_data_i  (fill_data_i),
        .fill_error_i (fill_error_i),
        .fill_last_i  (fill_last_i),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .write_addr_o (write_addr_o),
        .write_set_o  (write_set_o),
        .write_data_o (write_data_o),
        .write_tag_o  (write_tag_o),
        .write_error_o(write_error_o),
        .write_valid_o(write_valid_o),
        .write_ready_i(write_ready_i),
        .done_id_o    (done_id_o),
        .done_valid_o (done_valid_o)
    );

    // Victim reference: which set the next completed refill must land in
`ifdef SNITCH_ICACHE_REFILL_LFSR_EN
    logic [7:0] vstate = 8'hA5;
    function automatic logic model_set();
        return vstate[0];
    endfunction
    task automatic model_advance();
        vstate = {vstate[6:0], vstate[7] ^ vstate[5] ^ vstate[4] ^ vstate[3]};
    endtask
    task automatic model_flush();
        vstate = 8'hA5;
    endtask
`else
    int vstate = 0;
    function automatic logic model_set();
        return (vstate % 2) == 1;
    endfunction
    task automatic model_advance();
        vstate = (vstate + 1) % 2;
    endtask
    task automatic model_flush();
        vstate = 0;
    endtask
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every write handshake must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (rst_ni && write_valid_o && write_ready_i) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got write addr %0h, expected none", write_addr_o);
            end else begin
                mon_e = q.pop_front();
                chk("write_addr", 128'(write_addr_o), 128'(mon_e.addr));
                chk("write_tag", 128'(write_tag_o), 128'(mon_e.tag));
                chk("write_set", 128'(write_set_o), 128'(mon_e.set));
                chk("write_data", write_data_o, mon_e.data);
                chk("write_error", 128'(write_error_o), 128'(mon_e.err));
                chk("done_valid", 128'(done_valid_o), 128'(1));
                chk("done_id", 128'(done_id_o), 128'(mon_e.id));
            end
        end
    end

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no handshake, expected one within 50 cycles", name);
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [3:0] id);
        int g;
        req_addr_i  = addr;
        req_id_i    = id;
        req_valid_i = 1'b1;
        g = 0;
        while (!req_ready_o && g < 50) begin tick(); g++; end
        if (g >= 50) timeout("req_handshake");
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic e, input logic last);
        int g;
        repeat ($urandom_range(0, 2)) tick();
        fill_valid_i = 1'b1;
        fill_data_i  = d;
        fill_error_i = e;
        fill_last_i  = last;
        g = 0;
        while (!fill_ready_o && g < 50) begin tick(); g++; end
        if (g >= 50) timeout("fill_handshake");
        tick();
        fill_valid_i = 1'b0;
        fill_last_i  = 1'b0;
        fill_error_i = 1'b0;
    endtask

    task automatic idle_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        model_flush();
    endtask

    // One full refill; nb beats offered, the last one flagged with last_fin
    task automatic refill(input logic [31:0] addr, input logic [3:0] id, input int nb,
                          input logic last_fin, input logic e0, input logic e1,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input int stall, input logic flush_hs);
        exp_t         e;
        logic [127:0] snap_d;
        logic [21:0]  snap_t;
        e.addr = addr[9:4];
        e.tag  = addr[31:10];
        e.id   = id;
        e.set  = model_set();
        e.data = (nb == 2) ? {d1, d0} : {64'h0, d0};
        e.err  = e0 | ((nb == 2) && e1) | (nb != 2) | !last_fin;
        q.push_back(e);
        send_req(addr, id);
        send_beat(d0, e0, (nb == 1) ? last_fin : 1'b0);
        if (nb == 2) send_beat(d1, e1, last_fin);
        chk("write_valid_latency", 128'(write_valid_o), 128'(1));
        snap_d = write_data_o;
        snap_t = write_tag_o;
        write_ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_data", write_data_o, snap_d);
            chk("stall_tag", 128'(write_tag_o), 128'(snap_t));
            chk("stall_valid", 128'(write_valid_o), 128'(1));
            chk("stall_req_ready", 128'(req_ready_o), 128'(0));
            chk("stall_fill_ready", 128'(fill_ready_o), 128'(0));
            chk("stall_done", 128'(done_valid_o), 128'(0));
        end
        write_ready_i = 1'b1;
        flush_i       = flush_hs;
        tick();
        write_ready_i = 1'b0;
        flush_i       = 1'b0;
        if (flush_hs) model_flush();
        else model_advance();
        chk("write_valid_drop", 128'(write_valid_o), 128'(0));
        chk("req_ready_back", 128'(req_ready_o), 128'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready_o), 128'(1));
        chk({tag, "_fill_ready"}, 128'(fill_ready_o), 128'(0));
        chk({tag, "_write_valid"}, 128'(write_valid_o), 128'(0));
        chk({tag, "_done_valid"}, 128'(done_valid_o), 128'(0));
        chk({tag, "_write_data"}, write_data_o, 128'(0));
        chk({tag, "_write_tag"}, 128'(write_tag_o), 128'(0));
        chk({tag, "_write_addr"}, 128'(write_addr_o), 128'(0));
        chk({tag, "_write_error"}, 128'(write_error_o), 128'(0));
        chk({tag, "_write_set"}, 128'(write_set_o), 128'(model_set()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          nb;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        req_addr_i    = '0;
        req_id_i      = '0;
        req_valid_i   = 1'b0;
        fill_data_i   = '0;
        fill_error_i  = 1'b0;
        fill_last_i   = 1'b0;
        fill_valid_i  = 1'b0;
        write_ready_i = 1'b0;
        model_flush();
        repeat (3) tick();
        check_reset_values("reset");
        rst_ni = 1'b1;
        tick();

        // Directed: clean two-beat line at 0x1230
        refill(32'h0000_1230, 4'h5, 2, 1'b1, 1'b0, 1'b0,
               64'hAAAA_AAAA_0000_000A, 64'hBBBB_BBBB_0000_000B, 0, 1'b0);
        // Back-to-back refills with a flush before the third
        idle_flush();
        refill(32'h0000_4560, 4'h1, 2, 1'b1, 1'b0, 1'b0, 64'h11, 64'h12, 0, 1'b0);
        refill(32'h0000_4570, 4'h2, 2, 1'b1, 1'b0, 1'b0, 64'h21, 64'h22, 0, 1'b0);
        idle_flush();
        refill(32'h0000_4580, 4'h3, 2, 1'b1, 1'b0, 1'b0, 64'h31, 64'h32, 0, 1'b0);
        // Error on beat 0; early last on beat 0; missing last on final beat
        refill(32'hDEAD_BEE0, 4'h7, 2, 1'b1, 1'b1, 1'b0, 64'h41, 64'h42, 0, 1'b0);
        refill(32'hCAFE_0010, 4'h8, 1, 1'b1, 1'b0, 1'b0, 64'h51, 64'h0, 0, 1'b0);
        refill(32'h1234_5670, 4'h9, 2, 1'b0, 1'b0, 1'b0, 64'h61, 64'h62, 0, 1'b0);
        // Long write stall, then flush coinciding with the write handshake
        refill(32'h0F0F_0F00, 4'hA, 2, 1'b1, 1'b0, 1'b0, 64'h71, 64'h72, 10, 1'b0);
        refill(32'h0000_0040, 4'hB, 2, 1'b1, 1'b0, 1'b0, 64'h81, 64'h82, 1, 1'b1);
        refill(32'h0000_0050, 4'hC, 2, 1'b1, 1'b0, 1'b0, 64'h91, 64'h92, 0, 1'b0);

        // Reset in the middle of a refill drops it
        send_req(32'h7777_7770, 4'hD);
        send_beat(64'hDEAD, 1'b0, 1'b0);
        rst_ni = 1'b0;
        model_flush();
        #1;
        check_reset_values("midreset");
        write_ready_i = 1'b1;
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        chk("midreset_no_write", 128'(write_valid_o), 128'(0));
        write_ready_i = 1'b0;

        // Randomized refills
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) idle_flush();
            a  = $urandom;
            nb = $urandom_range(1, 2);
            refill(a, 4'($urandom), nb,
                   (nb == 1) ? 1'b1 : ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        repeat (3) tick();
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
